// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: format codes, opcode match constants and field positions for imm_ext_pipe
package imm_ext_pkg;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_CB   = 3'd1,
    FMT_B    = 3'd2,
    FMT_D    = 3'd3,
    FMT_I    = 3'd4,
    FMT_IW   = 3'd5
  } fmt_t;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;
  localparam int CB_LSB = 5;
  localparam int CB_W   = 19;
  localparam int B_W    = 26;
  localparam int D_LSB  = 12;
  localparam int D_W    = 9;
  localparam int I_LSB  = 10;
  localparam int I_W    = 12;
  localparam int IW_LSB = 5;
  localparam int IW_W   = 16;
  localparam int HW_LSB = 21;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational LEGv8 format classifier and immediate extender
module imm_decode
  import imm_ext_pkg::*;
#(
  parameter int N           = 64,
  parameter bit BYTE_OFFSET = 1'b0
) (
  input  logic [31:0]  instr,
  output logic [N-1:0] imm,
  output logic [2:0]   fmt
);
  logic is_cb, is_b, is_d, is_i, is_iw;
  logic [N-1:0] cb, b, d, i, iw;
  logic unused_bits;
  assign is_cb = instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ;
  assign is_b  = instr[31:26] == OP_B || instr[31:26] == OP_BL;
  assign is_d  = instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR;
  assign is_i  = instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI;
  assign is_iw = instr[31:23] == OP_MOVZ;
  assign cb = {{(N-CB_W){instr[CB_LSB+CB_W-1]}}, instr[CB_LSB +: CB_W]} << (BYTE_OFFSET ? 2 : 0);
  assign b  = {{(N-B_W){instr[B_W-1]}}, instr[B_W-1:0]} << (BYTE_OFFSET ? 2 : 0);
  assign d  = {{(N-D_W){instr[D_LSB+D_W-1]}}, instr[D_LSB +: D_W]};
  assign i  = N'(instr[I_LSB +: I_W]);
  assign iw = N'(instr[IW_LSB +: IW_W]) << {instr[HW_LSB +: 2], 4'b0};
  assign unused_bits = ^instr[4:0];
  // first matching format wins; anything unmatched decodes to zero
  always_comb begin
    fmt = is_cb ? FMT_CB : is_b ? FMT_B : is_d ? FMT_D : is_i ? FMT_I : is_iw ? FMT_IW : FMT_NONE;
    imm = is_cb ? cb : is_b ? b : is_d ? d : is_i ? i : is_iw ? iw : '0;
  end
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate extender with a 2-entry output FIFO and unknown-format counter
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int N           = 64,
  parameter bit BYTE_OFFSET = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     imm,
  output logic [2:0]       fmt,
  output logic [CNT_W-1:0] unknown_cnt
);
  logic [N+2:0] mem [2];
  logic [N-1:0] d_imm;
  logic [2:0]   d_fmt;
  logic [1:0]   count, count_nx;
  logic         wr, rd, push, pop;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = count != 2'd0;
  assign count_nx  = count + {1'b0, push} - {1'b0, pop};
  assign {imm, fmt} = mem[rd];
  imm_decode #(.N(N), .BYTE_OFFSET(BYTE_OFFSET)) u_dec (
    .instr(push ? instr : 32'd0),
    .imm  (d_imm),
    .fmt  (d_fmt)
  );
  // FIFO storage, wrap pointers, occupancy and registered ready
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr       <= 1'b0;
      rd       <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      if (push) mem[wr] <= {d_imm, d_fmt};
      wr       <= wr ^ push;
      rd       <= rd ^ pop;
      count    <= count_nx;
      in_ready <= count_nx != 2'd2;
    end
  // saturating count of accepted words with no immediate format
  always_ff @(posedge clk or negedge reset)
    if (!reset) unknown_cnt <= '0;
    else if (push && d_fmt == FMT_NONE && !(&unknown_cnt)) unknown_cnt <= unknown_cnt + CNT_W'(1);
endmodule
